counter_mem_bist_master: RTL and testbench

Avalon-MM master that drives the single-port on-chip RAM slave: fills it with a selectable pattern, reads every word back and compares against the regenerated expected value. It sits next to the on-chip memory in the counter system and provides a self-test that runs after boot or on software request. The slave has fixed read latency and no waitrequest, so this master tracks outstanding reads with a latency pipeline.

---
 rtl/counter_mem_bist_master.sv | 195 +++++++++++++++++++
 tb/tb_counter_mem_bist_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_mem_bist_master.sv
// Avalon-MM memory self-test master: writes a pattern to every word of a fixed-latency
// RAM slave, then reads it back and records mismatches.
module counter_mem_bist_master #(
  parameter int ADDR_WIDTH   = 14,
  parameter int NUM_WORDS    = 10024,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [1:0]              pattern_sel_i,
  input  logic [DATA_WIDTH-1:0]   seed_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             fail_count_o,
  output logic [ADDR_WIDTH-1:0]   first_fail_addr_o,
  output logic [DATA_WIDTH-1:0]   first_fail_data_o,
  output logic [ADDR_WIDTH-1:0]   address_o,
  output logic [DATA_WIDTH/8-1:0] byteenable_o,
  output logic                    chipselect_o,
  output logic                    write_o,
  output logic [DATA_WIDTH-1:0]   writedata_o,
  output logic                    clken_o,
  input  logic [DATA_WIDTH-1:0]   readdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  function automatic logic [DATA_WIDTH-1:0] pattern_f(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] sel,
                                                      input logic [DATA_WIDTH-1:0] sd);
    logic [DATA_WIDTH-1:0] ax;
    ax = DATA_WIDTH'(a);
    case (sel)
      2'd0:    pattern_f = ax;
      2'd1:    pattern_f = ~ax;
      2'd2:    pattern_f = sd;
      2'd3:    pattern_f = a[0] ? ~sd : sd;
      default: pattern_f = ax;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    cs_q, cs_d, wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]             fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   ffa_q, ffa_d;
  logic [DATA_WIDTH-1:0]   ffd_q, ffd_d;
  logic [1:0]              sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [2:0]              drain_q, drain_d;
  logic [BE_W-1:0]         be_q;
  logic [READ_LATENCY-1:0] pv_q;
  logic [ADDR_WIDTH-1:0]   pa_q [READ_LATENCY];
  logic                    mismatch_s, last_s;

  // The pipeline tail marks the cycle in which readdata belongs to a read issued earlier
  assign mismatch_s = pv_q[READ_LATENCY-1] &&
                      (readdata_i != pattern_f(pa_q[READ_LATENCY-1], sel_q, seed_q));
  assign last_s     = (addr_q == ADDR_WIDTH'(NUM_WORDS - 1));

  // Next-state and next-output logic for the test sequencer
  always_comb begin
    state_d = state_q;  addr_d = addr_q;   cs_d = cs_q;     wr_d = wr_q;
    wdata_d = wdata_q;  busy_d = busy_q;   done_d = done_q; pass_d = pass_q;
    fail_d  = fail_q;   ffa_d  = ffa_q;    ffd_d = ffd_q;   sel_d = sel_q;
    seed_d  = seed_q;   drain_d = drain_q;

    if (mismatch_s) begin
      if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
      else                    fail_d = fail_q;
      // fail_count never wraps back to zero, so zero means no mismatch seen yet
      if (fail_q == 16'd0) begin
        ffa_d = pa_q[READ_LATENCY-1];
        ffd_d = readdata_i;
      end else begin
        ffa_d = ffa_q;
        ffd_d = ffd_q;
      end
    end else begin
      fail_d = fail_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = WRITE;
          sel_d   = pattern_sel_i;
          seed_d  = seed_i;
          fail_d  = 16'd0;
          ffa_d   = {ADDR_WIDTH{1'b0}};
          ffd_d   = {DATA_WIDTH{1'b0}};
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          addr_d  = {ADDR_WIDTH{1'b0}};
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          wdata_d = pattern_f({ADDR_WIDTH{1'b0}}, pattern_sel_i, seed_i);
        end else begin
          state_d = state_q;
        end
      end
      WRITE: begin
        if (last_s) begin
          state_d = READ;
          addr_d  = {ADDR_WIDTH{1'b0}};
          wr_d    = 1'b0;
          wdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          wdata_d = pattern_f(addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1}, sel_q, seed_q);
        end
      end
      READ: begin
        if (last_s) begin
          state_d = DRAIN;
          addr_d  = {ADDR_WIDTH{1'b0}};
          cs_d    = 1'b0;
          drain_d = 3'd0;
        end else begin
          addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        if (drain_q == 3'(READ_LATENCY - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_d == 16'd0);
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered bus/status outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;                addr_q  <= {ADDR_WIDTH{1'b0}};
      cs_q    <= 1'b0;                wr_q    <= 1'b0;
      wdata_q <= {DATA_WIDTH{1'b0}};  busy_q  <= 1'b0;
      done_q  <= 1'b0;                pass_q  <= 1'b0;
      fail_q  <= 16'd0;               ffa_q   <= {ADDR_WIDTH{1'b0}};
      ffd_q   <= {DATA_WIDTH{1'b0}};  sel_q   <= 2'd0;
      seed_q  <= {DATA_WIDTH{1'b0}};  drain_q <= 3'd0;
      be_q    <= {BE_W{1'b0}};
    end else begin
      state_q <= state_d;  addr_q  <= addr_d;   cs_q   <= cs_d;   wr_q   <= wr_d;
      wdata_q <= wdata_d;  busy_q  <= busy_d;   done_q <= done_d; pass_q <= pass_d;
      fail_q  <= fail_d;   ffa_q   <= ffa_d;    ffd_q  <= ffd_d;  sel_q  <= sel_d;
      seed_q  <= seed_d;   drain_q <= drain_d;
      be_q    <= cs_d ? {BE_W{1'b1}} : {BE_W{1'b0}};
    end
  end

  // Read-latency tracker: valid bit and address of each outstanding read
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      pv_q[0] <= (state_q == READ);
      pa_q[0] <= addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end

  assign busy_o            = busy_q;
  assign clken_o           = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign fail_count_o      = fail_q;
  assign first_fail_addr_o = ffa_q;
  assign first_fail_data_o = ffd_q;
  assign address_o         = addr_q;
  assign byteenable_o      = be_q;
  assign chipselect_o      = cs_q;
  assign write_o           = wr_q;
  assign writedata_o       = wdata_q;

endmodule

// File: tb/tb_counter_mem_bist_master.sv
// Scoreboard bench: two masters (read latency 1 and 3) test 16-word RAM models
// with optional fault injection.
module tb_counter_mem_bist_master;
  localparam int AW = 14;
  localparam int N  = 16;
  localparam int DW = 32;

  typedef struct {int cyc; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} bus_t;
  typedef struct {int cyc; logic [15:0] fc; logic pass; logic [AW-1:0] ffa; logic [DW-1:0] ffd;} res_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] psel = 2'd0;
  logic [DW-1:0] seed = 32'd0;
  int cyc = 0, n_chk = 0, n_err = 0, fault_mode = 0;

  logic busy1, done1, pass1, cs1, wr1, clken1, busy3, done3, pass3, cs3, wr3, clken3;
  logic [15:0] fc1, fc3;
  logic [AW-1:0] ffa1, ffa3, addr1, addr3;
  logic [DW-1:0] ffd1, ffd3, wd1, wd3, rd1, rd3;
  logic [3:0] be1, be3;

  bus_t bq[$];
  res_t rq1[$], rq3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_mem_bist_master #(.ADDR_WIDTH(AW), .NUM_WORDS(N), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pattern_sel_i(psel), .seed_i(seed),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_count_o(fc1),
    .first_fail_addr_o(ffa1), .first_fail_data_o(ffd1), .address_o(addr1),
    .byteenable_o(be1), .chipselect_o(cs1), .write_o(wr1), .writedata_o(wd1),
    .clken_o(clken1), .readdata_i(rd1));

  counter_mem_bist_master #(.ADDR_WIDTH(AW), .NUM_WORDS(N), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pattern_sel_i(psel), .seed_i(seed),
    .busy_o(busy3), .done_o(done3), .pass_o(pass3), .fail_count_o(fc3),
    .first_fail_addr_o(ffa3), .first_fail_data_o(ffd3), .address_o(addr3),
    .byteenable_o(be3), .chipselect_o(cs3), .write_o(wr3), .writedata_o(wd3),
    .clken_o(clken3), .readdata_i(rd3));

  function automatic logic [DW-1:0] pat(input int a, input logic [1:0] ps, input logic [DW-1:0] sd);
    logic [DW-1:0] ax;
    ax = 32'(a);
    case (ps)
      2'd0:    return ax;
      2'd1:    return ~ax;
      2'd2:    return sd;
      default: return ax[0] ? ~sd : sd;
    endcase
  endfunction

  function automatic logic [DW-1:0] flt(input int a, input logic [DW-1:0] d);
    if (fault_mode == 1 && a == 5) return d & ~32'h8;
    if (fault_mode == 2)           return d ^ 32'h1;
    return d;
  endfunction

  // RAM models: latency-1 and latency-3 read paths
  logic [DW-1:0] mem1 [16], mem3 [16];
  logic [DW-1:0] r3a, r3b;
  always @(posedge clk) begin
    if (cs1 && wr1) mem1[addr1[3:0]] <= wd1;
    rd1 <= flt(int'(addr1[3:0]), mem1[addr1[3:0]]);
    if (cs3 && wr3) mem3[addr3[3:0]] <= wd3;
    r3a <= flt(int'(addr3[3:0]), mem3[addr3[3:0]]);
    r3b <= r3a;
    rd3 <= r3b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bus monitor for the latency-1 master
  always @(negedge clk) begin
    if (!reset && cs1) begin
      if (bq.size() == 0) check("bus_extra", 32'd1, 32'd0);
      else begin
        bus_t e;
        e = bq.pop_front();
        check("bus_cyc", cyc, e.cyc);
        check("bus_wr", {31'd0, wr1}, {31'd0, e.wr});
        check("bus_addr", {18'd0, addr1}, {18'd0, e.addr});
        check("bus_be", {28'd0, be1}, 32'hF);
        if (e.wr) check("bus_wdata", wd1, e.data);
      end
    end
  end

  // Completion monitors
  logic dprev1 = 1'b0, dprev3 = 1'b0;
  always @(negedge clk) begin
    res_t r;
    if (!reset && done1 && !dprev1) begin
      if (rq1.size() == 0) check("done1_extra", 32'd1, 32'd0);
      else begin
        r = rq1.pop_front();
        check("done1_cyc", cyc, r.cyc);
        check("fc1", {16'd0, fc1}, {16'd0, r.fc});
        check("pass1", {31'd0, pass1}, {31'd0, r.pass});
        check("ffa1", {18'd0, ffa1}, {18'd0, r.ffa});
        check("ffd1", ffd1, r.ffd);
        check("busy1_done", {31'd0, busy1}, 32'd0);
        check("clken1_done", {31'd0, clken1}, 32'd0);
      end
    end
    if (!reset && done3 && !dprev3) begin
      if (rq3.size() == 0) check("done3_extra", 32'd1, 32'd0);
      else begin
        r = rq3.pop_front();
        check("done3_cyc", cyc, r.cyc);
        check("fc3", {16'd0, fc3}, {16'd0, r.fc});
        check("pass3", {31'd0, pass3}, {31'd0, r.pass});
        check("ffa3", {18'd0, ffa3}, {18'd0, r.ffa});
        check("ffd3", ffd3, r.ffd);
      end
    end
    dprev1 = done1;
    dprev3 = done3;
  end

  task automatic check_reset_outputs();
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_pass", {31'd0, pass1}, 32'd0);
    check("rst_fc", {16'd0, fc1}, 32'd0);
    check("rst_ffa", {18'd0, ffa1}, 32'd0);
    check("rst_ffd", ffd1, 32'd0);
    check("rst_addr", {18'd0, addr1}, 32'd0);
    check("rst_be", {28'd0, be1}, 32'd0);
    check("rst_cs", {31'd0, cs1}, 32'd0);
    check("rst_wr", {31'd0, wr1}, 32'd0);
    check("rst_wd", wd1, 32'd0);
    check("rst_clken", {31'd0, clken1}, 32'd0);
    check("rst3_fc", {16'd0, fc3}, 32'd0);
    check("rst3_done", {31'd0, done3}, 32'd0);
    check("rst3_cs", {31'd0, cs3}, 32'd0);
  endtask

  task automatic launch(input logic [1:0] ps, input logic [DW-1:0] sd, input int fm, input bit extra_start);
    int k, fc;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd, p, r;
    res_t res;
    fault_mode = fm;
    @(posedge clk); #1;
    start = 1'b1; psel = ps; seed = sd;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0; psel = ~ps; seed = ~sd;
    fc = 0; fa = '0; fd = '0;
    for (int a = 0; a < N; a++) begin
      p = pat(a, ps, sd);
      bq.push_back('{k + a, 1'b1, AW'(a), p});
      r = flt(a, p);
      if (r != p) begin
        if (fc == 0) begin fa = AW'(a); fd = r; end
        fc++;
      end
    end
    for (int a = 0; a < N; a++) bq.push_back('{k + N + a, 1'b0, AW'(a), 32'd0});
    res = '{k + 2*N + 1, 16'(fc), (fc == 0), fa, fd};
    rq1.push_back(res);
    res.cyc = k + 2*N + 3;
    rq3.push_back(res);
    if (extra_start) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic wait_results();
    for (int i = 0; i < 300 && (rq1.size() != 0 || rq3.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    check("run_timeout", rq1.size() + rq3.size(), 32'd0);
    check("bus_left", bq.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs();
    repeat (5) @(posedge clk);
    #1 check_reset_outputs();

    launch(2'd0, 32'd0, 0, 1'b1);
    wait_results();
    launch(2'd3, 32'hA5A5A5A5, 0, 1'b0);
    wait_results();
    launch(2'd1, 32'd0, 1, 1'b0);
    wait_results();
    launch(2'd0, 32'd0, 2, 1'b0);
    wait_results();

    launch(2'd1, 32'd0, 2, 1'b0);
    repeat (N + 5) @(posedge clk);
    #1 reset = 1'b1;
    bq.delete(); rq1.delete(); rq3.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs();
    launch(2'd2, 32'h1234ABCD, 0, 1'b0);
    wait_results();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
